// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: funct3 access formats,
// FSM state type and the access-size helper.
package data_mem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  // Access size in bytes: 1/2/4/8 from the low two funct3 bits.
  function automatic logic [3:0] access_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
interface data_mem_ctrl_if #(parameter int XLEN = 64);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl_array.sv
// Byte-write-enable RAM with one XLEN-wide aligned port; combinational read.
// Contents are zero at time zero and are never cleared by reset.
module dmem_byte_array #(
  parameter  int XLEN      = 64,
  parameter  int MEM_BYTES = 2048,
  localparam int NB        = XLEN / 8,
  localparam int WORDS     = MEM_BYTES / NB,
  localparam int IW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [NB-1:0]   be,
  input  logic [IW-1:0]   idx,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller: RISC-V load/store formats,
// alignment/range/format checking, sign/zero extension, IDLE/RESP handshake.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 2048
) (
  input logic             clk,
  input logic             rst,
  data_mem_ctrl_if.slave  bus
);
  localparam int NB    = XLEN / 8;
  localparam int OB    = $clog2(NB);
  localparam int WORDS = MEM_BYTES / NB;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [2:0]      f3;
  logic [3:0]      size;
  logic [OB-1:0]   off;
  logic [IW-1:0]   idx;
  logic            illegal, misal, oor, err;
  logic [XLEN:0]   end_addr;
  logic [NB:0]     mask;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wsh, mem_rd, lane, ld;
  logic            accept, mem_we;

  assign f3   = bus.req_funct3;
  assign size = access_size(f3);
  assign off  = bus.req_addr[OB-1:0];
  assign idx  = IW'(bus.req_addr >> OB);

  always_comb begin
    illegal = bus.req_we ? f3[2] : (f3 == 3'b111);
    if (XLEN == 32 && (f3 == F3_D || (!bus.req_we && f3 == F3_WU))) illegal = 1'b1;
  end

  // Range check is done one bit wider so addresses near 2^XLEN cannot wrap.
  assign misal    = (bus.req_addr[2:0] & (size[2:0] - 3'd1)) != 3'd0;
  assign end_addr = {1'b0, bus.req_addr} + (XLEN+1)'(size);
  assign oor      = end_addr > (XLEN+1)'(MEM_BYTES);
  assign err      = illegal | misal | oor;

  assign mask   = ((NB+1)'(1) << size) - (NB+1)'(1);
  assign be     = mask[NB-1:0] << off;
  assign wsh    = bus.req_wdata << {off, 3'b000};
  assign lane   = mem_rd >> {off, 3'b000};
  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign mem_we = accept && bus.req_we && !err;

  always_comb begin
    ld = '0;
    case (f3)
      F3_B:  begin ld = {XLEN{lane[7]}};  ld[7:0]  = lane[7:0];  end
      F3_H:  begin ld = {XLEN{lane[15]}}; ld[15:0] = lane[15:0]; end
      F3_W:  begin ld = {XLEN{lane[31]}}; ld[31:0] = lane[31:0]; end
      F3_D:  ld = lane;
      F3_BU: ld[7:0]  = lane[7:0];
      F3_HU: ld[15:0] = lane[15:0];
      F3_WU: ld[31:0] = lane[31:0];
      default: ld = '0;
    endcase
  end

  dmem_byte_array #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be),
    .idx   (idx),
    .wdata (wsh),
    .rdata (mem_rd)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_RESP;
        err_d   = err;
        rdata_d = (err || bus.req_we) ? '0 : ld;
      end
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed + randomized bench for data_mem_ctrl against a byte-array model.
module tb_data_mem_ctrl;
  localparam int XLEN = 64;
  localparam int MEM  = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.XLEN(XLEN)) bus();

  data_mem_ctrl #(.XLEN(XLEN), .MEM_BYTES(MEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  ref_mem [MEM];
  logic [63:0] exp_rd;
  logic        exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, rules applied with plain arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] rd, output logic e);
    int sz = 1 << f3[1:0];
    bit ill = we ? (f3 > 3'd3) : (f3 == 3'd7);
    logic [64:0] endp = {1'b0, addr} + 65'(sz);
    e  = ill || (addr % 64'(sz) != 0) || (endp > 65'(MEM));
    rd = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) rd[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!f3[2] && sz < 8 && rd[8*sz-1]) rd = rd | (~64'd0 << (8*sz));
      end
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 0;
    model(we, f3, addr, wd, exp_rd, exp_err);
    chk("resp_valid", bus.resp_valid, 1);
    chk("resp_rdata", bus.resp_rdata, exp_rd);
    chk("resp_err", bus.resp_err, exp_err);
    chk("req_ready_in_resp", bus.req_ready, 0);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.resp_ready = 1;
    @(posedge clk); #1;
    bus.resp_ready = 0;
    chk("resp_released", bus.resp_valid, 0);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] wd);
    send(we, f3, addr, wd);
    ack();
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;

    #12;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_err, 0);
    @(negedge clk); rst = 0;

    // SD then LD round trip
    txn(1, 3'b011, 64'h10, 64'h1122334455667788);
    send(0, 3'b011, 64'h10, 0);
    chk("ld_0x10", bus.resp_rdata, 64'h1122334455667788);
    chk("ld_0x10_err", bus.resp_err, 0);
    ack();

    // SB then signed / unsigned byte loads
    txn(1, 3'b000, 64'h21, 64'h80);
    send(0, 3'b000, 64'h21, 0);
    chk("lb_0x21", bus.resp_rdata, 64'hFFFFFFFFFFFFFF80);
    ack();
    send(0, 3'b100, 64'h21, 0);
    chk("lbu_0x21", bus.resp_rdata, 64'h80);
    ack();

    // Misaligned SW must not disturb its neighbours
    txn(1, 3'b011, 64'h00, 64'h5555555555555555);
    txn(1, 3'b011, 64'h08, 64'hAAAAAAAAAAAAAAAA);
    send(1, 3'b010, 64'h06, 64'h12345678);
    chk("sw_misaligned_err", bus.resp_err, 1);
    ack();
    send(0, 3'b011, 64'h08, 0);
    chk("ld_0x08_intact", bus.resp_rdata, 64'hAAAAAAAAAAAAAAAA);
    ack();
    send(0, 3'b010, 64'h04, 0);
    chk("lw_0x04_intact", bus.resp_rdata, 64'h0000000055555555);
    ack();

    // Upper boundary
    send(0, 3'b011, 64'(MEM - 8), 0);
    chk("ld_last_ok", bus.resp_err, 0);
    ack();
    send(0, 3'b011, 64'(MEM), 0);
    chk("ld_oor_err", bus.resp_err, 1);
    ack();
    send(0, 3'b011, 64'(MEM - 4), 0);
    chk("ld_misal_err", bus.resp_err, 1);
    ack();

    // Consumer stall: response held, new request ignored
    send(0, 3'b011, 64'h10, 0);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b011;
    bus.req_addr = 64'h40; bus.req_wdata = 64'hDEADBEEFCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", bus.resp_valid, 1);
      chk("stall_rdata", bus.resp_rdata, 64'h1122334455667788);
      chk("stall_req_ready", bus.req_ready, 0);
    end
    @(negedge clk); bus.req_valid = 0;
    ack();
    send(0, 3'b011, 64'h40, 0);
    chk("ignored_store", bus.resp_rdata, 64'h0);
    ack();

    // Reset during RESP keeps the committed store
    send(1, 3'b001, 64'h30, 64'hBEEF);
    #2 rst = 1;
    #1;
    chk("rst_mid_valid", bus.resp_valid, 0);
    chk("rst_mid_ready", bus.req_ready, 1);
    @(negedge clk); rst = 0;
    send(0, 3'b101, 64'h30, 0);
    chk("lhu_after_rst", bus.resp_rdata, 64'hBEEF);
    ack();

    // Randomized traffic, mostly in a small window so loads hit prior stores
    for (int k = 0; k < 300; k++) begin
      logic [63:0] a;
      int r = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, 63));
      else if (r == 7) a = 64'(MEM - 16 + $urandom_range(0, 15));
      else if (r == 8) a = 64'(MEM + $urandom_range(0, 8));
      else             a = {$urandom, $urandom};
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width (32 or 64 only).
REQ-002 SHALL have parameter MEM_BYTES, default 2048, byte capacity (power of two, >= 8).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3 access format.
REQ-009 SHALL have port req_addr  input  XLEN  byte address.
REQ-010 SHALL have port req_wdata  input  XLEN  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal format.

Function
REQ-015 Request accepted on edge where req_valid && req_ready; FSM states IDLE and RESP only.
REQ-016 req_ready = 1 exactly in IDLE; IDLE -> RESP on acceptance.
REQ-017 RESP: resp_valid = 1; resp_rdata/resp_err stable until handshake; RESP -> IDLE on resp_ready.
REQ-018 Latency: resp_valid asserts the cycle after acceptance; with resp_ready held high, throughput is one request per 2 cycles.
REQ-019 Load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; signed forms sign-extend, unsigned forms zero-extend to XLEN.
REQ-020 Store funct3: 000 SB, 001 SH, 010 SW, 011 SD; writes low 1/2/4/8 bytes of req_wdata.
REQ-021 Byte order little-endian: byte at addr = bits [7:0].
REQ-022 Illegal format -> resp_err: 111 on load; funct3[2] set on store; LD, LWU or SD when XLEN = 32.
REQ-023 Misaligned (addr not multiple of access size) -> resp_err; no memory modification.
REQ-024 Out-of-range (addr + size > MEM_BYTES, full XLEN compare, no wrap) -> resp_err; no modification.
REQ-025 Stores commit on the acceptance edge; a load accepted later returns the stored bytes.
REQ-026 Load data captured on the acceptance edge into a response register; the memory array is not read while in RESP.
REQ-027 Error precedence: illegal format, then misaligned, then out-of-range; all yield the same resp_err = 1.

Reset
REQ-028 rst asserted: state IDLE, req_ready = 1 after release, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-029 rst mid-RESP drops the pending response; a store already committed stays committed.
REQ-030 Memory array is not cleared by rst; initialised to all-zero at time zero.

Structure
REQ-031 Shared package holds funct3 load/store encodings, access-size function and FSM state typedef.
REQ-032 One sub-module natural: dmem_byte_array (byte-write-enable RAM, XLEN-wide aligned port).
REQ-033 Extension/alignment logic stays combinational in data_mem_ctrl.

Verification
REQ-034 SD 0x1122334455667788 @0x10, then LD @0x10 -> rdata 0x1122334455667788, err 0.
REQ-035 SB 0x80 @0x21; LB @0x21 -> 0xFFFFFFFFFFFFFF80; LBU @0x21 -> 0x80.
REQ-036 SW @0x06 -> resp_err = 1, memory @0x04..0x0B unchanged (readback via LD @0x08 and LW @0x04).
REQ-037 LD @MEM_BYTES-8 -> err 0; LD @MEM_BYTES -> err 1; LD @MEM_BYTES-4 -> err 1 (misaligned).
REQ-038 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready = 0 throughout; new req_valid ignored.
REQ-039 rst pulse during RESP after SH 0xBEEF @0x30 -> resp_valid = 0 immediately; later LHU @0x30 -> 0xBEEF.
